exec_unit_pipe: RTL

Parametrised execute stage for the NoobsCpu datapath, sitting between decode/register-read and register writeback/data memory. It generalises the 8-bit single-cycle execute block. Additions: configurable data and address widths, a valid/ready operation handshake, a status-flag register, shift, add-with-carry and conditional-branch ops, a multi-cycle shift-add multiplier, and a wait-capable data-memory port that writes load data back into the register file.

---
 rtl/exec_unit_pipe.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit_pipe.sv
// Execute stage for the NoobsCpu datapath: single-cycle ALU and branch ops,
// an iterative shift-add multiplier and a wait-capable data-memory port.
module exec_unit_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_vld,
  output logic              op_rdy,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_vld,
  input  logic [2:0]        dst_reg,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              reg_wr_en,
  output logic [2:0]        reg_wr_sel,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [3:0]        flags,
  output logic              br_taken,
  output logic [ADDR_W-1:0] tgt_addr,
  output logic              d_mem_en,
  output logic              d_mem_rd,
  output logic              d_mem_wr,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic [DATA_W-1:0] d_mem_data_out,
  input  logic [DATA_W-1:0] d_mem_data_in,
  input  logic              d_mem_rdy
);

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_OR  = 4'd3,  OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5,  OP_LD  = 4'd6,  OP_ST  = 4'd7,  OP_JMP = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9,  OP_JC  = 4'd10, OP_SHL = 4'd11, OP_SHR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13, OP_ADC = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_MEM  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                op_rdy_r;
  logic                accept_s;
  logic [DATA_W-1:0]   opb_s;
  logic                add_cin_s;
  logic [DATA_W:0]     sum_s;
  logic [DATA_W-1:0]   diff_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_c_s, alu_v_s, alu_wr_s, br_s;
  logic [3:0]          alu_flags_s;
  logic [3:0]          op_r;
  logic [2:0]          dst_reg_r;
  logic [2*DATA_W-1:0] acc_r, mcand_r, mul_prod_s;
  logic [DATA_W-1:0]   mplier_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [3:0]          mul_flags_s;

  logic              reg_wr_en_r, br_taken_r, d_mem_en_r, d_mem_rd_r, d_mem_wr_r;
  logic [2:0]        reg_wr_sel_r;
  logic [DATA_W-1:0] reg_wr_data_r, d_mem_data_out_r;
  logic [3:0]        flags_r;
  logic [ADDR_W-1:0] tgt_addr_r, d_mem_addr_r;

  assign accept_s  = op_vld && op_rdy_r;
  assign opb_s     = imm_vld ? imm : src1;
  assign add_cin_s = (op == OP_ADC) ? flags_r[1] : 1'b0;
  assign sum_s     = {1'b0, src0} + {1'b0, opb_s} + {{DATA_W{1'b0}}, add_cin_s};
  assign diff_s    = src0 - opb_s;
  assign alu_flags_s = {alu_v_s, alu_res_s[MSB], alu_c_s, (alu_res_s == {DATA_W{1'b0}})};

  // The last shift-add step is folded in combinationally so the product lands on time.
  assign mul_prod_s  = acc_r + (mplier_r[0] ? mcand_r : {(2*DATA_W){1'b0}});
  assign mul_flags_s = {1'b0, mul_prod_s[MSB],
                        (mul_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}}),
                        (mul_prod_s[MSB:0] == {DATA_W{1'b0}})};

  // Single-cycle ALU result, flag candidates and branch decision for the presented op.
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_wr_s  = 1'b0;
    br_s      = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res_s = sum_s[MSB:0];
        alu_c_s   = sum_s[DATA_W];
        alu_v_s   = (src0[MSB] == opb_s[MSB]) && (sum_s[MSB] != src0[MSB]);
        alu_wr_s  = 1'b1;
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_c_s   = (src0 < opb_s);
        alu_v_s   = (src0[MSB] != opb_s[MSB]) && (diff_s[MSB] != src0[MSB]);
        alu_wr_s  = 1'b1;
      end
      OP_OR:  begin alu_res_s = src0 | opb_s; alu_wr_s = 1'b1; end
      OP_AND: begin alu_res_s = src0 & opb_s; alu_wr_s = 1'b1; end
      OP_XOR: begin alu_res_s = src0 ^ opb_s; alu_wr_s = 1'b1; end
      OP_SHL: begin
        alu_res_s = {src0[MSB-1:0], 1'b0};
        alu_c_s   = src0[MSB];
        alu_wr_s  = 1'b1;
      end
      OP_SHR: begin
        alu_res_s = {1'b0, src0[MSB:1]};
        alu_c_s   = src0[0];
        alu_wr_s  = 1'b1;
      end
      OP_JMP:  br_s = 1'b1;
      OP_JZ:   br_s = flags_r[0];
      OP_JC:   br_s = flags_r[1];
      default: br_s = 1'b0;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_EXEC: begin
        if (!accept_s) begin
          state_nxt_s = S_IDLE;
        end else if (op == OP_MUL) begin
          state_nxt_s = S_MUL;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
          state_nxt_s = S_MEM;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_MUL: begin
        if (cnt_r == CNT_LAST) state_nxt_s = S_EXEC;
        else                   state_nxt_s = S_MUL;
      end
      S_MEM: begin
        if (d_mem_rdy) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_MEM;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      op_rdy_r <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      op_rdy_r <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_EXEC);
    end
  end

  // Datapath: operand capture, multiplier iterations, memory handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 4'd0;  dst_reg_r <= 3'd0;  cnt_r <= {CNT_W{1'b0}};
      acc_r <= {(2*DATA_W){1'b0}};  mcand_r <= {(2*DATA_W){1'b0}};  mplier_r <= {DATA_W{1'b0}};
      reg_wr_en_r <= 1'b0;  reg_wr_sel_r <= 3'd0;  reg_wr_data_r <= {DATA_W{1'b0}};
      flags_r <= 4'd0;  br_taken_r <= 1'b0;  tgt_addr_r <= {ADDR_W{1'b0}};
      d_mem_en_r <= 1'b0;  d_mem_rd_r <= 1'b0;  d_mem_wr_r <= 1'b0;
      d_mem_addr_r <= {ADDR_W{1'b0}};  d_mem_data_out_r <= {DATA_W{1'b0}};
    end else begin
      reg_wr_en_r <= 1'b0;
      br_taken_r  <= 1'b0;
      case (state_r)
        S_IDLE, S_EXEC: begin
          if (accept_s) begin
            op_r      <= op;
            dst_reg_r <= dst_reg;
            if (op == OP_MUL) begin
              acc_r    <= {(2*DATA_W){1'b0}};
              mcand_r  <= {{DATA_W{1'b0}}, src0};
              mplier_r <= opb_s;
              cnt_r    <= {CNT_W{1'b0}};
            end else if ((op == OP_LD) || (op == OP_ST)) begin
              d_mem_en_r       <= 1'b1;
              d_mem_rd_r       <= (op == OP_LD);
              d_mem_wr_r       <= (op == OP_ST);
              d_mem_addr_r     <= dst_addr;
              d_mem_data_out_r <= src0;
            end else begin
              reg_wr_en_r <= alu_wr_s;
              br_taken_r  <= br_s;
              if (alu_wr_s) begin
                reg_wr_sel_r  <= dst_reg;
                reg_wr_data_r <= alu_res_s;
                flags_r       <= alu_flags_s;
              end
              if (br_s) tgt_addr_r <= dst_addr;
            end
          end
        end
        S_MUL: begin
          acc_r    <= mul_prod_s;
          mcand_r  <= {mcand_r[2*DATA_W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[MSB:1]};
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            reg_wr_en_r   <= 1'b1;
            reg_wr_sel_r  <= dst_reg_r;
            reg_wr_data_r <= mul_prod_s[MSB:0];
            flags_r       <= mul_flags_s;
          end
        end
        S_MEM: begin
          if (d_mem_rdy) begin
            d_mem_en_r <= 1'b0;
            d_mem_rd_r <= 1'b0;
            d_mem_wr_r <= 1'b0;
            if (op_r == OP_LD) begin
              reg_wr_en_r   <= 1'b1;
              reg_wr_sel_r  <= dst_reg_r;
              reg_wr_data_r <= d_mem_data_in;
            end
          end
        end
        default: reg_wr_en_r <= 1'b0;
      endcase
    end
  end

  assign op_rdy         = op_rdy_r;
  assign reg_wr_en      = reg_wr_en_r;
  assign reg_wr_sel     = reg_wr_sel_r;
  assign reg_wr_data    = reg_wr_data_r;
  assign flags          = flags_r;
  assign br_taken       = br_taken_r;
  assign tgt_addr       = tgt_addr_r;
  assign d_mem_en       = d_mem_en_r;
  assign d_mem_rd       = d_mem_rd_r;
  assign d_mem_wr       = d_mem_wr_r;
  assign d_mem_addr     = d_mem_addr_r;
  assign d_mem_data_out = d_mem_data_out_r;

endmodule
